// File: rtl/axixorshift_pkg.sv
// Shared shift triples, default seeds, FSM encodings and the xorshift step
// function used by the streaming random source.
package axixorshift_pkg;

    localparam int unsigned XS32_SH_A = 13;
    localparam int unsigned XS32_SH_B = 17;
    localparam int unsigned XS32_SH_C = 5;
    localparam int unsigned XS64_SH_A = 13;
    localparam int unsigned XS64_SH_B = 7;
    localparam int unsigned XS64_SH_C = 17;

    localparam logic [31:0] XS32_DEFAULT_SEED = 32'd1;
    localparam logic [63:0] XS64_DEFAULT_SEED = 64'd1;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_LOAD = 1'b1;

    // One xorshift step on the low 'width' bits; every stage is truncated to width.
    function automatic logic [63:0] xs_step(input logic [63:0]   x,
                                            input int unsigned   width,
                                            input int unsigned   sh_a,
                                            input int unsigned   sh_b,
                                            input int unsigned   sh_c);
        logic [63:0] mask;
        logic [63:0] v;
        mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        v    = x & mask;
        v    = (v ^ (v << sh_a)) & mask;
        v    = v ^ (v >> sh_b);
        v    = (v ^ (v << sh_c)) & mask;
        return v;
    endfunction

endpackage

// File: rtl/axixorshift_stream_fifo.sv
// First-word-fall-through synchronous FIFO with flush, used as the
// prefetch buffer between the generator and the read channel.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [LW-1:0]    count_q, count_d;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + AW'(1);
            if (pop)  rptr_d = rptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + LW'(1);
                2'b01:   count_d = count_q - LW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wptr_q] <= wdata;
    end

    assign rdata = mem_q[rptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == LW'(DEPTH));
    assign level = count_q;

endmodule

// File: rtl/axixorshift_stream.sv
// Streaming xorshift random source: state register, RUN/LOAD control and
// valid/ready seed-write and random-read channels around a prefetch FIFO.
module axixorshift_stream
    import axixorshift_pkg::*;
#(
    parameter int unsigned     WIDTH        = 32,
    parameter int unsigned     SH_A         = (WIDTH == 64) ? XS64_SH_A : XS32_SH_A,
    parameter int unsigned     SH_B         = (WIDTH == 64) ? XS64_SH_B : XS32_SH_B,
    parameter int unsigned     SH_C         = (WIDTH == 64) ? XS64_SH_C : XS32_SH_C,
    parameter int unsigned     DEPTH        = 4,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(XS64_DEFAULT_SEED)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   wdatavalid,
    output logic                   wdataready,
    output logic [WIDTH-1:0]       rdata,
    output logic                   rdatavalid,
    input  logic                   rdataready,
    output logic [$clog2(DEPTH):0] level
);

    if (!(WIDTH == 32 || WIDTH == 64)) begin : g_bad_width
        $error("axixorshift_stream: WIDTH must be 32 or 64");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("axixorshift_stream: DEPTH must be a power of two, at least 2");
    end
    if (DEFAULT_SEED == '0) begin : g_bad_seed
        $error("axixorshift_stream: DEFAULT_SEED must be nonzero");
    end

    logic [WIDTH-1:0] x_q, x_d, x_step;
    logic [0:0]       state_q, state_d;
    logic             seed_load;
    logic             pop;
    logic             push;
    logic             fifo_full;
    logic             fifo_empty;

    assign x_step     = WIDTH'(xs_step(64'(x_q), WIDTH, SH_A, SH_B, SH_C));
    assign wdataready = !rst;
    assign seed_load  = wdatavalid && wdataready;
    assign rdatavalid = !fifo_empty;
    assign pop        = rdatavalid && rdataready;
    // A pop on the same edge frees the slot the push needs, so a full FIFO still streams.
    assign push       = !seed_load && (!fifo_full || pop);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        case (state_q)
            ST_LOAD: state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
        if (seed_load) begin
            x_d     = (wdata == '0) ? DEFAULT_SEED : wdata;
            state_d = ST_LOAD;
        end else if (push) begin
            x_d = x_step;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q     <= DEFAULT_SEED;
            state_q <= ST_RUN;
        end else begin
            x_q     <= x_d;
            state_q <= state_d;
        end
    end

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (seed_load),
        .wdata (x_step),
        .rdata (rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

endmodule

// File: tb/tb_axixorshift_stream.sv
// Scoreboard bench for axixorshift_stream: a 32-bit default instance and a
// 64-bit (13,7,17) instance, checked against independent xorshift models.
module tb_axixorshift_stream;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst;

    logic [31:0] wd32, rd32;
    logic        wv32, wr32, rdv32, rdr32;
    logic [2:0]  lvl32;

    logic [63:0] wd64, rd64;
    logic        wv64, wr64, rdv64, rdr64;
    logic [2:0]  lvl64;

    int          n_pass  = 0;
    int          n_total = 0;

    logic [31:0] q32[$];
    logic [31:0] mx32;
    int          mlvl32;
    logic [63:0] q64[$];
    logic [63:0] mx64;
    int          mlvl64;
    int          n64;

    always #5 clk = ~clk;

    axixorshift_stream u_dut32 (
        .clk        (clk),
        .rst        (rst),
        .wdata      (wd32),
        .wdatavalid (wv32),
        .wdataready (wr32),
        .rdata      (rd32),
        .rdatavalid (rdv32),
        .rdataready (rdr32),
        .level      (lvl32)
    );

    axixorshift_stream #(
        .WIDTH (64),
        .SH_A  (13),
        .SH_B  (7),
        .SH_C  (17)
    ) u_dut64 (
        .clk        (clk),
        .rst        (rst),
        .wdata      (wd64),
        .wdatavalid (wv64),
        .wdataready (wr64),
        .rdata      (rd64),
        .rdatavalid (rdv64),
        .rdataready (rdr64),
        .level      (lvl64)
    );

    function automatic logic [31:0] m32(input logic [31:0] x);
        logic [31:0] v;
        v = x;
        v = v ^ (v << 13);
        v = v ^ (v >> 17);
        v = v ^ (v << 5);
        return v;
    endfunction

    function automatic logic [63:0] m64(input logic [63:0] x);
        logic [63:0] v;
        v = x;
        v = v ^ (v << 13);
        v = v ^ (v >> 7);
        v = v ^ (v << 17);
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic reseed32(input logic [31:0] s);
        q32.delete();
        mx32 = s;
        repeat (D) begin
            mx32 = m32(mx32);
            q32.push_back(mx32);
        end
    endtask

    task automatic reseed64(input logic [63:0] s);
        q64.delete();
        mx64 = s;
        repeat (D) begin
            mx64 = m64(mx64);
            q64.push_back(mx64);
        end
    endtask

    task automatic exp32(output logic [31:0] e);
        if (q32.size() == 0) begin
            mx32 = m32(mx32);
            q32.push_back(mx32);
        end
        e = q32.pop_front();
    endtask

    task automatic exp64(output logic [63:0] e);
        if (q64.size() == 0) begin
            mx64 = m64(mx64);
            q64.push_back(mx64);
        end
        e = q64.pop_front();
    endtask

    // One cycle on the 32-bit instance: check at negedge, update model, advance.
    task automatic cyc32();
        logic        pop;
        logic        push;
        logic [31:0] e;
        @(negedge clk);
        check("level32", 64'(lvl32), 64'(mlvl32));
        check("rdatavalid32", 64'(rdv32), 64'(mlvl32 != 0));
        check("wdataready32", 64'(wr32), 64'(!rst));
        pop = (mlvl32 != 0) && rdr32;
        if (pop) begin
            exp32(e);
            check("rdata32", 64'(rd32), 64'(e));
        end
        if (rst) begin
            mlvl32 = 0;
            reseed32(32'd1);
        end else if (wv32) begin
            mlvl32 = 0;
            reseed32((wd32 == 32'd0) ? 32'd1 : wd32);
        end else begin
            push   = (mlvl32 != D) || pop;
            mlvl32 = mlvl32 + int'(push) - int'(pop);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc64();
        logic        pop;
        logic        push;
        logic [63:0] e;
        @(negedge clk);
        check("level64", 64'(lvl64), 64'(mlvl64));
        check("rdatavalid64", 64'(rdv64), 64'(mlvl64 != 0));
        pop = (mlvl64 != 0) && rdr64;
        if (pop) begin
            exp64(e);
            check("rdata64", rd64, e);
            n64++;
        end
        if (rst) begin
            mlvl64 = 0;
            reseed64(64'd1);
        end else if (wv64) begin
            mlvl64 = 0;
            reseed64((wd64 == 64'd0) ? 64'd1 : wd64);
        end else begin
            push   = (mlvl64 != D) || pop;
            mlvl64 = mlvl64 + int'(push) - int'(pop);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        wv32  = 1'b0;
        wd32  = '0;
        rdr32 = 1'b1;
        wv64  = 1'b0;
        wd64  = '0;
        rdr64 = 1'b0;
        n64   = 0;
        @(posedge clk);
        #1;
        mlvl32 = 0;
        reseed32(32'd1);

        // Reset held, then released with the consumer always ready.
        repeat (2) cyc32();
        rst = 1'b0;
        cyc32();
        check("first_valid", 64'(rdv32), 64'd1);
        check("first_word", 64'(rd32), 64'h0000_0000_0004_2021);
        repeat (8) cyc32();

        // Zero seed behaves as seed 1; valid drops for exactly one cycle.
        wv32 = 1'b1;
        wd32 = 32'd0;
        cyc32();
        wv32 = 1'b0;
        cyc32();
        check("zero_seed_word", 64'(rd32), 64'h0000_0000_0004_2021);
        repeat (6) cyc32();

        // Backpressure: FIFO fills and holds, then drains in order.
        rdr32 = 1'b0;
        repeat (10) cyc32();
        check("full_level", 64'(lvl32), 64'd4);
        rdr32 = 1'b1;
        repeat (10) cyc32();

        // Seed load colliding with a read at level 3.
        rdr32 = 1'b0;
        wv32  = 1'b1;
        wd32  = 32'h1234_5678;
        cyc32();
        wv32  = 1'b0;
        repeat (3) cyc32();
        check("level_three", 64'(lvl32), 64'd3);
        rdr32 = 1'b1;
        wv32  = 1'b1;
        wd32  = 32'hDEAD_BEEF;
        cyc32();
        wv32  = 1'b0;
        cyc32();
        check("deadbeef_valid", 64'(rdv32), 64'd1);
        check("deadbeef_word", 64'(rd32), 64'(m32(32'hDEAD_BEEF)));
        repeat (6) cyc32();

        // Reset mid-stream with the FIFO full; the concurrent seed is ignored.
        rdr32 = 1'b0;
        repeat (6) cyc32();
        check("full_before_rst", 64'(lvl32), 64'd4);
        rst  = 1'b1;
        wv32 = 1'b1;
        wd32 = 32'h0000_5555;
        cyc32();
        rst  = 1'b0;
        wv32 = 1'b0;
        check("level_after_rst", 64'(lvl32), 64'd0);
        cyc32();
        check("rst_restart_word", 64'(rd32), 64'h0000_0000_0004_2021);
        rdr32 = 1'b1;
        repeat (6) cyc32();

        // 64-bit instance: has sat full since the last reset; reseed with 1.
        mlvl64 = D;
        reseed64(64'd1);
        wv64 = 1'b1;
        wd64 = 64'd1;
        cyc64();
        wv64 = 1'b0;
        cyc64();
        check("first_word64", rd64, 64'h0000_0000_4082_2041);
        for (int c = 0; c < 6000 && n64 < 1000; c++) begin
            rdr64 = 1'($urandom_range(0, 1));
            cyc64();
        end
        check("words64", 64'(n64), 64'd1000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/axixorshift_stream.md
# axixorshift_stream

Parametrised AXI-style pseudo-random source: a WIDTH-bit xorshift generator feeding a DEPTH-entry prefetch FIFO, with a valid/ready seed-write channel and a valid/ready random-read channel. The block is the next generation of the 32-bit xorshift peripheral. It adds selectable width and shift triple, zero-seed protection, back-to-back output at one word per cycle, and seed reload that flushes stale prefetched values. It sits behind the AXI channel adapters as a streaming random-number slave.

## Interface
Parameters:
- WIDTH, 32: word width; legal values 32 or 64. Any other value is an elaboration error.
- SH_A, 13: first left shift.
- SH_B, 17: right shift.
- SH_C, 5: second left shift.
- DEPTH, 4: prefetch FIFO entries; power of two, minimum 2.
- DEFAULT_SEED, 1: state after reset and substitute for a zero seed; must be nonzero.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- wdata  in  WIDTH  seed value.
- wdatavalid  in  1  seed write valid.
- wdataready  out  1  seed write ready.
- rdata  out  WIDTH  random word, taken from the FIFO head.
- rdatavalid  out  1  FIFO not empty.
- rdataready  in  1  consumer ready.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Step function, in order: x ^= x<<SH_A; x ^= x>>SH_B; x ^= x<<SH_C. All operations are truncated to WIDTH bits.
- The state register holds x. The state register is never zero.
- Generate: on each edge with no seed load and the FIFO not full (or full with a pop this edge):
  - push step(x);
  - x <= step(x).
- Read: when rdatavalid && rdataready, pop the FIFO head. rdata holds its value while valid && !ready.
- Seed load, on wdatavalid && wdataready:
  - x <= (wdata==0) ? DEFAULT_SEED : wdata;
  - FIFO is flushed (level <= 0);
  - no push on this edge.
- wdataready is 1 in every cycle except the cycle in which rst is high.
- States: RUN (normal) and LOAD (one cycle after a seed load, FIFO empty). LOAD goes to RUN unconditionally.
- Simultaneous seed load and read on the same edge: the read completes with the old head word, then the flush applies. Nothing from the old sequence survives.
- Simultaneous push and pop with the FIFO full: both occur, and level is unchanged.
- Pointers wrap modulo DEPTH. level ranges 0..DEPTH.

## Timing
- During rst and the first edge after it:
  - x=DEFAULT_SEED;
  - level=0;
  - rdatavalid=0;
  - wdataready=0 while rst is high;
  - rdata is don't-care while invalid.
- First edge after rst deasserts: push step(DEFAULT_SEED). rdatavalid=1 one cycle after reset release.
- Sustained throughput: 1 word per cycle with rdataready held high, with no bubbles.
- With rdataready low, the FIFO fills to DEPTH in DEPTH cycles, then generation stalls and x is frozen.
- Seed load latency:
  - edge N accepts the seed;
  - cycle N+1: rdatavalid=0 and level=0;
  - edge N+1 pushes step(seed);
  - rdatavalid=1 from cycle N+2.
- rst asserted mid-stream: at the next edge, the FIFO empties and x=DEFAULT_SEED. A seed offered in that same cycle is ignored.

## Structure
- Package axixorshift_pkg holds:
  - the default shift triples (32-bit: 13,17,5; 64-bit: 13,7,17);
  - the default seeds;
  - a step function parametrised by width and shifts.
- Sub-module sync_fifo (WIDTH, DEPTH) provides:
  - push, pop and flush;
  - full, empty and level outputs;
  - first-word-fall-through output.
- The top level holds the state register, the RUN/LOAD state machine, and the channel handshake logic.

## Test plan
- Reset then rdataready=1, WIDTH=32, default parameters -> words 0x00042021, then successive step() values, with rdatavalid continuous from cycle 1.
- Seed 0 written -> behaves exactly as seed 1: first post-load word 0x00042021, rdatavalid low exactly one cycle.
- rdataready=0 for 10 cycles, DEPTH=4 -> level reaches 4 at cycle 4 and holds. Releasing rdataready yields 4 in-order words, then continues the sequence with no gap or skipped value.
- Seed 0xDEADBEEF written while level=3 and a read occurs on the same edge:
  - the read returns the old head;
  - the next valid word is step(0xDEADBEEF);
  - none of the old words appear.
- WIDTH=64, shifts 13,7,17, seed 1 -> output matches a software xorshift64 model for 1000 words under random rdataready.
- rst pulsed mid-stream with the FIFO full -> level=0 next cycle, and the output restarts at step(DEFAULT_SEED).
